// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Counter width large enough to hold the biggest terminal count.
   function automatic int cnt_width(input int hold_cycles, input int stage_gap, input int lock_filter);
      int biggest;
      biggest = hold_cycles;
      if (stage_gap > biggest) biggest = stage_gap;
      if (lock_filter > biggest) biggest = lock_filter;
      return $clog2(biggest + 1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Two-stage bit synchronizer with asynchronous active-low clear.
module sync_ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Holds subsystems in reset, waits for a stable PLL lock, then releases
// the per-stage resets one at a time in index order.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int LOCK_FILTER = 4,
   parameter int STAGE_GAP   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_pll_locked,
   input  logic                  i_soft_rst,
   output logic [NUM_STAGES-1:0] o_rst,
   output logic                  o_done,
   output logic [1:0]            o_state
);

   localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, LOCK_FILTER);
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         filt;
   logic [IW-1:0]         idx;
   logic [NUM_STAGES-1:0] rst_q;
   logic                  done_q;
   logic                  lock_s;
   logic                  restart;

   sync_ff u_lock_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .d     (i_pll_locked),
      .q     (lock_s)
   );

   // Lock loss only restarts once stages have begun to come out of reset.
   assign restart = i_soft_rst || (!lock_s && (state == RELEASE || state == RUN));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= HOLD;
         cnt    <= '0;
         filt   <= '0;
         idx    <= '0;
         rst_q  <= '1;
         done_q <= 1'b0;
      end else if (restart) begin
         state  <= HOLD;
         cnt    <= '0;
         filt   <= '0;
         idx    <= '0;
         rst_q  <= '1;
         done_q <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == CW'(HOLD_CYCLES - 1)) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WAIT_LOCK: begin
               if (!lock_s) begin
                  filt <= '0;
               end else if (filt == CW'(LOCK_FILTER - 1)) begin
                  filt     <= '0;
                  cnt      <= '0;
                  rst_q[0] <= 1'b0;
                  if (NUM_STAGES == 1) begin
                     state  <= RUN;
                     done_q <= 1'b1;
                  end else begin
                     state <= RELEASE;
                     idx   <= IW'(1);
                  end
               end else begin
                  filt <= filt + 1'b1;
               end
            end

            RELEASE: begin
               if (cnt == CW'(STAGE_GAP - 1)) begin
                  cnt        <= '0;
                  rst_q[idx] <= 1'b0;
                  if (idx == IW'(NUM_STAGES - 1)) begin
                     state  <= RUN;
                     done_q <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RUN: begin
            end
         endcase
      end
   end

   assign o_rst   = rst_q;
   assign o_done  = done_q;
   assign o_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues every expected output change tagged with
// the clock edge after which it must appear; a monitor pops on each change.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_rst;
   logic [2:0] rst;
   logic       done;
   logic [1:0] state;

   typedef struct {
      int         cyc;
      logic [2:0] rst;
      logic       done;
      logic [1:0] state;
   } exp_t;

   exp_t expQ[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   event probe;

   reset_sequencer dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pll_locked (pll_locked),
      .i_soft_rst   (soft_rst),
      .o_rst        (rst),
      .o_done       (done),
      .o_state      (state)
   );

   always #5 clk = ~clk;

   // Edge number since the last reset release; edge 1 is the first one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic pushExp(input int c, input logic [2:0] r, input logic d, input logic [1:0] s);
      exp_t e;
      e.cyc   = c;
      e.rst   = r;
      e.done  = d;
      e.state = s;
      expQ.push_back(e);
   endtask

   // Nominal sequence with lock already stable, starting from HOLD after edge base.
   task automatic pushSeq(input int base);
      pushExp(base + 16, 3'b111, 1'b0, 2'd1);
      pushExp(base + 20, 3'b110, 1'b0, 2'd2);
      pushExp(base + 28, 3'b100, 1'b0, 2'd2);
      pushExp(base + 36, 3'b000, 1'b1, 2'd3);
   endtask

   task automatic waitCyc(input int n);
      do @(negedge clk); while (cyc != n);
   endtask

   task automatic checkOutput(input string what, input exp_t e);
      checks++;
      if (cyc !== e.cyc || rst !== e.rst || done !== e.done || state !== e.state) begin
         errors++;
         $display("[TB] FAIL %s: got edge=%0d rst=%b done=%b state=%0d, want edge=%0d rst=%b done=%b state=%0d",
                  what, cyc, rst, done, state, e.cyc, e.rst, e.done, e.state);
      end
   endtask

   // Monitor: any change in the outputs must match the head of the queue.
   initial begin
      logic [5:0] prev;
      prev = 'x;
      forever begin
         @(negedge clk or probe);
         if ({rst, done, state} !== prev) begin
            prev = {rst, done, state};
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_change: got edge=%0d rst=%b done=%b state=%0d, want no change",
                        cyc, rst, done, state);
            end else begin
               checkOutput("output_change", expQ.pop_front());
            end
         end else if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_change: got edge=%0d rst=%b done=%b state=%0d, want edge=%0d rst=%b done=%b state=%0d",
                     cyc, rst, done, state, expQ[0].cyc, expQ[0].rst, expQ[0].done, expQ[0].state);
            void'(expQ.pop_front());
         end
      end
   end

   task automatic applyStimulus();
      rst_n      = 1'b0;
      pll_locked = 1'b1;
      soft_rst   = 1'b0;
      pushExp(0, 3'b111, 1'b0, 2'd0);
      repeat (2) @(negedge clk);
      $display("[TB] nominal sequence");
      rst_n = 1'b1;
      pushSeq(0);

      waitCyc(40);
      $display("[TB] lock loss in RUN");
      pll_locked = 1'b0;
      pushExp(43, 3'b111, 1'b0, 2'd0);
      waitCyc(43);
      pll_locked = 1'b1;
      pushSeq(43);

      waitCyc(82);
      $display("[TB] soft reset in RUN, then lock glitch in WAIT_LOCK");
      soft_rst = 1'b1;
      pushExp(83, 3'b111, 1'b0, 2'd0);
      waitCyc(83);
      soft_rst = 1'b0;
      pushExp(99, 3'b111, 1'b0, 2'd1);
      pushExp(106, 3'b110, 1'b0, 2'd2);
      pushExp(114, 3'b100, 1'b0, 2'd2);
      pushExp(122, 3'b000, 1'b1, 2'd3);
      waitCyc(99);
      pll_locked = 1'b0;
      waitCyc(100);
      pll_locked = 1'b1;

      waitCyc(125);
      $display("[TB] soft reset colliding with stage-1 release");
      soft_rst = 1'b1;
      pushExp(126, 3'b111, 1'b0, 2'd0);
      waitCyc(126);
      soft_rst = 1'b0;
      pushExp(142, 3'b111, 1'b0, 2'd1);
      pushExp(146, 3'b110, 1'b0, 2'd2);
      waitCyc(153);
      soft_rst = 1'b1;
      pushExp(154, 3'b111, 1'b0, 2'd0);
      waitCyc(154);
      soft_rst = 1'b0;
      pushExp(170, 3'b111, 1'b0, 2'd1);
      pushExp(174, 3'b110, 1'b0, 2'd2);
      pushExp(182, 3'b100, 1'b0, 2'd2);

      waitCyc(185);
      $display("[TB] async reset mid-RELEASE");
      #2;
      rst_n = 1'b0;
      pushExp(0, 3'b111, 1'b0, 2'd0);
      #1;
      -> probe;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pushSeq(0);
      waitCyc(40);
   endtask

   initial begin
      applyStimulus();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL queue_drained: got %0d pending, want 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] timeout");
   end

endmodule
